// File: rtl/b03_req_gen_pkg.sv
// Shared definitions for the request generator and the arbiter.
// User states, user-to-bit mapping and default wait limit.
package b03_req_gen_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_GRANT = 2'd1,
        USE        = 2'd2,
        RELEASE    = 2'd3
    } user_state_e;

    // User n sits on bit (4 - n) of every 4-bit user vector.
    localparam int U1 = 3;
    localparam int U2 = 2;
    localparam int U3 = 1;
    localparam int U4 = 0;

    localparam logic [3:0] G_U1 = 4'b1000;
    localparam logic [3:0] G_U2 = 4'b0100;
    localparam logic [3:0] G_U3 = 4'b0010;
    localparam logic [3:0] G_U4 = 4'b0001;

    localparam int TIMEOUT_DEF = 16;

    function automatic logic [2:0] ones4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

endpackage

// File: rtl/b03_req_gen_if.sv
// Job/arbiter bundle of the request generator.
// master: the generator side; slave: job source plus arbiter.
interface b03_req_gen_if;

    logic [3:0] start;
    logic [3:0] len;
    logic [3:0] GRANT_I;
    logic       REQUEST1;
    logic       REQUEST2;
    logic       REQUEST3;
    logic       REQUEST4;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] timeout;
    logic       grant_err;
    logic [7:0] grant_cnt;

    modport master (
        input  start, len, GRANT_I,
        output REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        output busy, done, timeout, grant_err, grant_cnt
    );

    modport slave (
        output start, len, GRANT_I,
        input  REQUEST1, REQUEST2, REQUEST3, REQUEST4,
        input  busy, done, timeout, grant_err, grant_cnt
    );

endinterface

// File: rtl/b03_req_gen_user.sv
// One user: request, wait for a fresh grant, use, release.
// A grant already high on entry must drop before it is accepted.
module b03_user
    import b03_req_gen_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] len,
    input  logic       grant,
    output logic       request,
    output logic       busy,
    output logic       done,
    output logic       timeout,
    output logic       accept
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    user_state_e state_q, state_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  use_q, use_d;
    logic [7:0]  wait_q, wait_d;
    logic        armed_q, armed_d;
    logic        req_q;
    logic        done_q, done_d;
    logic        tmo_q, tmo_d;

    // Next state, counters and the grant-accept strobe.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        use_d   = use_q;
        wait_d  = wait_q;
        armed_d = armed_q;
        done_d  = 1'b0;
        tmo_d   = 1'b0;
        accept  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = WAIT_GRANT;
                    len_d   = (len == 4'd0) ? 4'd1 : len;
                    wait_d  = 8'd0;
                    armed_d = 1'b0;
                end
            end
            WAIT_GRANT: begin
                if (!grant) begin
                    armed_d = 1'b1;
                end
                if (armed_q && grant) begin
                    accept  = 1'b1;
                    state_d = USE;
                    use_d   = len_q;
                end else if (wait_q == WAIT_LAST) begin
                    state_d = RELEASE;
                    tmo_d   = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            USE: begin
                if (use_q <= 4'd1) begin
                    state_d = RELEASE;
                    done_d  = 1'b1;
                end else begin
                    use_d = use_q - 4'd1;
                end
            end
            RELEASE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, latches and registered request/pulse outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            len_q   <= 4'd0;
            use_q   <= 4'd0;
            wait_q  <= 8'd0;
            armed_q <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            use_q   <= use_d;
            wait_q  <= wait_d;
            armed_q <= armed_d;
            req_q   <= (state_d == WAIT_GRANT) || (state_d == USE);
            done_q  <= done_d;
            tmo_q   <= tmo_d;
        end
    end

    assign request = req_q;
    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign timeout = tmo_q;

endmodule

// File: rtl/b03_req_gen.sv
// Four independent requesters toward a shared arbiter.
// Also tracks accepted grants and flags multi-hot grants.
module b03_req_gen
    import b03_req_gen_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clock,
    input  logic          reset,
    b03_req_gen_if.master bus
);

    logic [3:0] req;
    logic [3:0] busy;
    logic [3:0] done;
    logic [3:0] tmo;
    logic [3:0] acc;
    logic [7:0] cnt_q;
    logic       err_q;
    logic [8:0] cnt_sum;

    for (genvar i = 0; i < 4; i++) begin : g_user
        b03_user #(
            .TIMEOUT (TIMEOUT)
        ) u_user (
            .clock   (clock),
            .reset   (reset),
            .start   (bus.start[i]),
            .len     (bus.len),
            .grant   (bus.GRANT_I[i]),
            .request (req[i]),
            .busy    (busy[i]),
            .done    (done[i]),
            .timeout (tmo[i]),
            .accept  (acc[i])
        );
    end

    // Several users may accept in the same cycle.
    always_comb begin
        cnt_sum = {1'b0, cnt_q} + 9'(ones4(acc));
    end

    // Saturating grant counter and sticky multi-hot flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= 8'd0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= (cnt_sum > 9'd255) ? 8'd255 : cnt_sum[7:0];
            if (ones4(bus.GRANT_I) > 3'd1) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.REQUEST1  = req[U1];
    assign bus.REQUEST2  = req[U2];
    assign bus.REQUEST3  = req[U3];
    assign bus.REQUEST4  = req[U4];
    assign bus.busy      = busy;
    assign bus.done      = done;
    assign bus.timeout   = tmo;
    assign bus.grant_err = err_q;
    assign bus.grant_cnt = cnt_q;

endmodule

// File: tb/tb_b03_req_gen.sv
// Bench for b03_req_gen: cycle vector tables plus a long
// back-to-back job run for grant counter saturation.
module tb_b03_req_gen;
    import b03_req_gen_pkg::*;

    typedef struct {
        int         tid;
        bit         rst;
        logic [3:0] start;
        logic [3:0] len;
        logic [3:0] gnt;
        logic [3:0] req;
        logic [3:0] busy;
        logic [3:0] done;
        logic [3:0] tmo;
        logic       err;
        logic [7:0] cnt;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    int checks = 0;
    int failures = 0;
    int cur_tid = 0;

    vec_t tbl[$];
    vec_t sb[$];
    logic [7:0] cnt_sb[$];

    b03_req_gen_if bus ();

    b03_req_gen #(
        .TIMEOUT (16)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] req_vec();
        return {bus.REQUEST1, bus.REQUEST2, bus.REQUEST3, bus.REQUEST4};
    endfunction

    task automatic add(input bit r, input logic [3:0] s, input logic [3:0] l,
                       input logic [3:0] g, input logic [3:0] rq,
                       input logic [3:0] b, input logic [3:0] d,
                       input logic [3:0] t, input logic e, input logic [7:0] c);
        vec_t v;
        v.tid = cur_tid; v.rst = r; v.start = s; v.len = l; v.gnt = g;
        v.req = rq; v.busy = b; v.done = d; v.tmo = t; v.err = e; v.cnt = c;
        tbl.push_back(v);
    endtask

    task automatic run_table();
        vec_t e;
        for (int i = 0; i < tbl.size(); i++) begin
            reset       = tbl[i].rst;
            bus.start   = tbl[i].start;
            bus.len     = tbl[i].len;
            bus.GRANT_I = tbl[i].gnt;
            sb.push_back(tbl[i]);
            @(posedge clock);
            #1;
            e = sb.pop_front();
            checks++;
            if ({req_vec(), bus.busy, bus.done, bus.timeout, bus.grant_err, bus.grant_cnt}
                !== {e.req, e.busy, e.done, e.tmo, e.err, e.cnt}) begin
                failures++;
                $display("FAIL t%0d vec%0d got req=%b busy=%b done=%b tmo=%b err=%b cnt=%0d exp req=%b busy=%b done=%b tmo=%b err=%b cnt=%0d",
                         e.tid, i, req_vec(), bus.busy, bus.done, bus.timeout,
                         bus.grant_err, bus.grant_cnt, e.req, e.busy, e.done,
                         e.tmo, e.err, e.cnt);
            end
        end
    endtask

    task automatic run_job(input int n);
        bit seen;
        logic [7:0] c;
        bus.start = G_U1; bus.len = 4'd0; bus.GRANT_I = 4'd0;
        @(posedge clock); #1;
        bus.start = 4'd0;
        @(posedge clock); #1;
        bus.GRANT_I = G_U1;
        cnt_sb.push_back((n > 255) ? 8'd255 : 8'(n));
        @(posedge clock); #1;
        bus.GRANT_I = 4'd0;
        seen = 1'b0;
        for (int w = 0; w < 8 && !seen; w++) begin
            @(posedge clock); #1;
            if (bus.done[U1]) seen = 1'b1;
        end
        c = cnt_sb.pop_front();
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL job%0d done never seen, cnt=%0d exp %0d", n, bus.grant_cnt, c);
        end else if (bus.grant_cnt !== c) begin
            failures++;
            $display("FAIL job%0d grant_cnt got %0d exp %0d", n, bus.grant_cnt, c);
        end
        @(posedge clock); #1;
    endtask

    initial begin
        bus.start = 4'd0; bus.len = 4'd0; bus.GRANT_I = 4'd0;

        // Test 1: user1, len 3, grant 4 cycles after request rises
        cur_tid = 1;
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h8, 4'd3, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd0);
        for (int k = 0; k < 4; k++)
            add(0, 4'h0, 4'd0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd0);
        for (int k = 0; k < 3; k++)
            add(0, 4'h0, 4'd0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 0, 8'd1);
        add(0, 4'h8, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);

        // Test 2: user2 never granted, times out after 16 wait cycles
        cur_tid = 2;
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h4, 4'd5, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 0, 8'd0);
        for (int k = 0; k < 15; k++)
            add(0, 4'h0, 4'd0, 4'h0, 4'h4, 4'h4, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h4, 4'h0, 4'h4, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);

        // Test 3: stale grant on user3 must drop before acceptance
        cur_tid = 3;
        add(1, 4'h0, 4'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h2, 4'd1, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h2, 4'h0, 4'h2, 4'h2, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);

        // Test 4: multi-hot grant, two acceptances, sticky error
        cur_tid = 4;
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'hC, 4'd1, 4'h0, 4'hC, 4'hC, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'hC, 4'hC, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'hC, 4'hC, 4'hC, 4'h0, 4'h0, 1, 8'd2);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'hC, 4'hC, 4'h0, 1, 8'd2);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'd2);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 1, 8'd2);
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);

        // Test 5: reset with user4 in use, coincident start ignored
        cur_tid = 5;
        add(0, 4'h1, 4'd5, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'h1, 4'd5, 4'h1, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);

        // Test 7: grant in the last wait cycle beats the timeout
        cur_tid = 7;
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h8, 4'd1, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd0);
        for (int k = 0; k < 15; k++)
            add(0, 4'h0, 4'd0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd0);
        add(0, 4'h0, 4'd0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h8, 4'h0, 4'h8, 4'h8, 4'h0, 0, 8'd1);
        add(0, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd1);
        add(1, 4'h0, 4'd0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 0, 8'd0);

        @(posedge clock); #1;
        run_table();

        // Test 6: 300 back-to-back len=0 jobs on user1
        reset = 1'b0;
        bus.start = 4'd0; bus.GRANT_I = 4'd0;
        for (int n = 1; n <= 300; n++)
            run_job(n);
        checks++;
        if (bus.grant_cnt !== 8'd255 || bus.busy !== 4'h0) begin
            failures++;
            $display("FAIL sat_final cnt=%0d busy=%b exp cnt=255 busy=0000",
                     bus.grant_cnt, bus.busy);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
